mips_multicycle_ctrl: RTL and testbench

//   Main control FSM for the multicycle MIPS datapath. Sequences the shared ALU, memory,
//   IR, PC and register file across FETCH..WRITEBACK. Drives the ALU's 2-bit aluOP and

---
 rtl/mips_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences the shared ALU, memory, IR, PC and register file from FETCH
// through WRITEBACK. Outputs are Moore-decoded from the current state; pc_en
// also folds in the ALU zero flag for beq.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   opcode         IR[31:26], sampled only in DECODE
//   zero           ALU zero flag, meaningful while alu_op = 2'b01
//   stall          hold state; write enables and pulses forced low
//   pc_en          PC load = pc_write | (branch & zero)
//   ir_write       IR load
//   mem_write      data memory write
//   reg_write      register file write
//   iord           memory address select (0 = PC, 1 = ALUOut)
//   reg_dst        register destination (0 = rt, 1 = rd)
//   mem_to_reg     write-back source (0 = ALUOut, 1 = MDR)
//   alu_src_a      ALU A select (0 = PC, 1 = A)
//   alu_src_b      ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   alu_op         00 add, 01 sub/compare, 10 funct
//   pc_src         00 ALU result, 01 ALUOut, 10 jump target
//   instr_done     one-cycle pulse in the last state of an instruction
//   illegal        one-cycle pulse in DECODE for an unknown opcode
//   state          current state (debug)
module mips_multicycle_ctrl #(
   parameter int unsigned OPW = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           stall,
   output logic           pc_en,
   output logic           ir_write,
   output logic           mem_write,
   output logic           reg_write,
   output logic           iord,
   output logic           reg_dst,
   output logic           mem_to_reg,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [1:0]     alu_op,
   output logic [1:0]     pc_src,
   output logic           instr_done,
   output logic           illegal,
   output logic [3:0]     state
);

   localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
   localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
   localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
   localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
   localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_ALUWB    = 4'd7,
      S_BEQ      = 4'd8,
      S_ADDI_EX  = 4'd9,
      S_ADDI_WB  = 4'd10,
      S_JUMP     = 4'd11
   } state_e;

   state_e         state_q, state_d;
   logic [OPW-1:0] opcode_q, opcode_d;
   logic           pc_write;
   logic           branch;

   // State and latched opcode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_FETCH;
         opcode_q <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

   // Next state and Moore output decode, then stall and reset gating
   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      pc_write   = 1'b0;
      branch     = 1'b0;
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      iord       = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            // ALU precomputes the branch target while the opcode is decoded
            alu_src_b = 2'b11;
            opcode_d  = opcode;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_RTYPE_EX;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_ADDI_EX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            // IR input may already have moved on; use the DECODE-time copy
            state_d   = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            mem_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_RTYPE_EX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // zero comes straight from the ALU, so a taken beq loads PC this cycle
      pc_en = pc_write | (branch & zero);

      // Stall freezes the FSM; selects stay valid, side effects are blocked
      if (stall) begin
         state_d    = state_q;
         opcode_d   = opcode_q;
         pc_en      = 1'b0;
         ir_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end

      // Reset kills everything combinationally so no write escapes mid-cycle
      if (rst) begin
         pc_en      = 1'b0;
         ir_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         iord       = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         alu_op     = 2'b00;
         pc_src     = 2'b00;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: each cycle the expected output
// vector is queued when stimulus is applied and the observed vector is queued
// at the falling edge; each test task drains and compares both queues.
module tb_mips_multicycle_ctrl;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_en;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic       iord;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       instr_done;
      logic       illegal;
   } obs_t;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic       zero;
   logic       stall;
   logic       pc_en, ir_write, mem_write, reg_write, iord, reg_dst;
   logic       mem_to_reg, alu_src_a, instr_done, illegal;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] state;

   obs_t obs;
   obs_t tbl [16];
   logic pcw_tbl [16];
   obs_t exp_q [$];
   obs_t got_q [$];
   int   n_checks;
   int   n_fail;

   mips_multicycle_ctrl #(.OPW(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .zero       (zero),
      .stall      (stall),
      .pc_en      (pc_en),
      .ir_write   (ir_write),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .iord       (iord),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_src     (pc_src),
      .instr_done (instr_done),
      .illegal    (illegal),
      .state      (state)
   );

   assign obs = {state, pc_en, ir_write, mem_write, reg_write, iord, reg_dst,
                 mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-state Moore outputs as listed in the state table
   function automatic void init_table();
      for (int i = 0; i < 16; i++) begin
         tbl[i]     = '0;
         pcw_tbl[i] = 1'b0;
      end
      tbl[0].ir_write   = 1'b1; tbl[0].alu_src_b = 2'b01; pcw_tbl[0] = 1'b1;
      tbl[1].alu_src_b  = 2'b11;
      tbl[2].alu_src_a  = 1'b1; tbl[2].alu_src_b = 2'b10;
      tbl[3].iord       = 1'b1;
      tbl[4].mem_to_reg = 1'b1; tbl[4].reg_write = 1'b1; tbl[4].instr_done = 1'b1;
      tbl[5].iord       = 1'b1; tbl[5].mem_write = 1'b1; tbl[5].instr_done = 1'b1;
      tbl[6].alu_src_a  = 1'b1; tbl[6].alu_op    = 2'b10;
      tbl[7].reg_dst    = 1'b1; tbl[7].reg_write = 1'b1; tbl[7].instr_done = 1'b1;
      tbl[8].alu_src_a  = 1'b1; tbl[8].alu_op    = 2'b01; tbl[8].pc_src = 2'b01;
      tbl[8].instr_done = 1'b1;
      tbl[9].alu_src_a  = 1'b1; tbl[9].alu_src_b = 2'b10;
      tbl[10].reg_write = 1'b1; tbl[10].instr_done = 1'b1;
      tbl[11].pc_src    = 2'b10; tbl[11].instr_done = 1'b1; pcw_tbl[11] = 1'b1;
   endfunction

   function automatic obs_t model(input logic [3:0] st, input logic z, input logic stl,
                                  input logic r, input logic bad);
      obs_t o;
      if (r) return '0;
      o         = tbl[st];
      o.st      = st;
      o.illegal = bad;
      o.pc_en   = pcw_tbl[st] | ((st == 4'd8) & z);
      if (stl) begin
         o.pc_en      = 1'b0;
         o.ir_write   = 1'b0;
         o.mem_write  = 1'b0;
         o.reg_write  = 1'b0;
         o.instr_done = 1'b0;
         o.illegal    = 1'b0;
      end
      return o;
   endfunction

   function automatic logic legal(input logic [5:0] op);
      return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
             op == OP_ADDI || op == OP_J;
   endfunction

   // Expected state sequence, first state in the low nibble
   function automatic logic [19:0] seq_of(input logic [5:0] op);
      case (op)
         OP_LW:   return {4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
         OP_SW:   return {4'd0, 4'd5, 4'd2, 4'd1, 4'd0};
         OP_R:    return {4'd0, 4'd7, 4'd6, 4'd1, 4'd0};
         OP_ADDI: return {4'd0, 4'd10, 4'd9, 4'd1, 4'd0};
         OP_BEQ:  return {4'd0, 4'd0, 4'd8, 4'd1, 4'd0};
         OP_J:    return {4'd0, 4'd0, 4'd11, 4'd1, 4'd0};
         default: return {4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
      endcase
   endfunction

   function automatic int len_of(input logic [5:0] op);
      case (op)
         OP_LW:                     return 5;
         OP_SW, OP_R, OP_ADDI:      return 4;
         OP_BEQ, OP_J:              return 3;
         default:                   return 2;
      endcase
   endfunction

   // One clock of stimulus: drive after the edge, record expected and observed
   task automatic cyc(input logic [5:0] opc, input logic z, input logic stl,
                      input logic r, input logic [3:0] st, input logic bad);
      @(posedge clk);
      #1;
      opcode = opc;
      zero   = z;
      stall  = stl;
      rst    = r;
      exp_q.push_back(model(st, z, stl, r, bad));
      @(negedge clk);
      got_q.push_back(obs);
   endtask

   // Whole instruction; opcode is random outside DECODE to prove it is latched
   task automatic issue(input logic [5:0] op, input logic z);
      logic [19:0] s;
      logic [3:0]  st;
      s = seq_of(op);
      for (int i = 0; i < len_of(op); i++) begin
         st = s[i*4 +: 4];
         cyc((st == 4'd1) ? op : 6'($urandom), z, 1'b0, 1'b0, st,
             (st == 4'd1) && !legal(op));
      end
   endtask

   task automatic test_reset();
      obs_t e, g;
      cyc(OP_LW, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
      cyc(OP_J, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
      issue(OP_J, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_rst_mid();
      obs_t e, g;
      cyc(6'($urandom), 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      cyc(OP_SW, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
      cyc(OP_R, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
      cyc(OP_R, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (mem_write !== 1'b0 || state !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_async: got mem_write=%b state=%0d expected 0/0", mem_write, state);
      end
      cyc(OP_LW, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
      issue(OP_J, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL rst_mid: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_lw();
      obs_t e, g;
      int   dones;
      dones = 0;
      issue(OP_LW, 1'b0);
      foreach (got_q[i]) dones += int'(got_q[i].instr_done);
      n_checks++;
      if (dones !== 1) begin
         n_fail++;
         $display("FAIL lw_done_count: got %0d expected 1", dones);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL lw: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_beq();
      obs_t e, g;
      issue(OP_BEQ, 1'b1);
      issue(OP_BEQ, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL beq: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_rtype_addi();
      obs_t e, g;
      issue(OP_R, 1'b0);
      issue(OP_ADDI, 1'b0);
      issue(OP_SW, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL rtype_addi: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_illegal();
      obs_t e, g;
      issue(OP_BAD, 1'b0);
      // illegal held back by stall, then reported once stall drops
      cyc(6'($urandom), 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      cyc(6'b000001, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1);
      cyc(6'b000001, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
      issue(OP_J, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL illegal: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_stall();
      obs_t e, g;
      cyc(6'($urandom), 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      cyc(6'($urandom), 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      cyc(OP_SW, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
      cyc(OP_LW, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
      for (int i = 0; i < 3; i++) cyc(OP_LW, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0);
      cyc(OP_LW, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
      issue(OP_J, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL stall: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t       e, g;
      logic [5:0] ops [8];
      ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BAD, 6'b110000};
      for (int n = 0; n < 24; n++)
         issue(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL back_to_back: got %h expected %h", g, e);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      opcode   = '0;
      zero     = 1'b0;
      stall    = 1'b0;
      init_table();
      test_reset();
      test_rst_mid();
      test_lw();
      test_beq();
      test_rtype_addi();
      test_illegal();
      test_stall();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
